// File: rtl/cpu_test_pkg.sv
// Shared types for the CPU self-check sequencer: FSM state encoding and
// the check-table entry layout (steps to run, register to read, expected value).
package cpu_test_pkg;

  localparam int CTS_DW  = 32;
  localparam int CTS_RAW = 5;
  localparam int CTS_CW  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } cts_state_t;

  // "reg" is a keyword, so the register-number field is called regno.
  typedef struct packed {
    logic [CTS_CW-1:0]  steps;
    logic [CTS_RAW-1:0] regno;
    logic [CTS_DW-1:0]  val;
  } cts_entry_t;

  function automatic logic [CTS_CW-1:0] sat_inc(input logic [CTS_CW-1:0] v);
    return (&v) ? v : v + CTS_CW'(1);
  endfunction

endpackage

// File: rtl/cts_table.sv
// Check table: NCHK entries held in plain registers, one write port and a
// combinational read port. Contents are deliberately not reset.
module cts_table
  import cpu_test_pkg::*;
#(
  parameter int NCHK = 8,
  parameter int IW   = $clog2(NCHK),
  parameter int EW   = $bits(cts_entry_t)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [NCHK];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_test_seq.sv
// Self-check sequencer: resets the core, alternates step bursts with register
// readback checks. Define CPU_TEST_SEQ_STOP_ON_FAIL_EN to stop at the first mismatch.
module cpu_test_seq
  import cpu_test_pkg::*;
#(
  parameter int DW      = CTS_DW,
  parameter int RAW     = CTS_RAW,
  parameter int NCHK    = 8,
  parameter int CW      = CTS_CW,
  parameter int RST_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(NCHK):0]  num_chk,
  input  logic                   cfg_we,
  input  logic [$clog2(NCHK)-1:0] cfg_idx,
  input  logic [CW-1:0]          cfg_steps,
  input  logic [RAW-1:0]         cfg_reg,
  input  logic [DW-1:0]          cfg_val,
  output logic                   cpu_rst,
  output logic                   cpu_step,
  output logic [RAW-1:0]         dbg_raddr,
  input  logic [DW-1:0]          dbg_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [$clog2(NCHK):0]  err_cnt,
  output logic [$clog2(NCHK)-1:0] fail_idx,
  output logic [CW-1:0]          cycle_cnt
);

  localparam int IW  = $clog2(NCHK);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int EW  = $bits(cts_entry_t);

  cts_state_t     state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [IW:0]    nchk_reg, nchk_next;
  logic [RCW-1:0] rst_cnt_reg, rst_cnt_next;
  logic [CW-1:0]  step_cnt_reg, step_cnt_next;
  logic           first_reg, first_next;
  logic [IW:0]    err_cnt_reg, err_cnt_next;
  logic [IW-1:0]  fail_idx_reg, fail_idx_next;
  logic [CW-1:0]  cycle_cnt_reg, cycle_cnt_next;

  logic       idle_ok;
  logic       tbl_we;
  cts_entry_t wr_entry;
  cts_entry_t rd_entry;
  logic [CW-1:0] eff_steps;
  logic       mismatch;
  logic       last;
  logic [IW:0] nchk_clamped;

  assign idle_ok = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign tbl_we  = cfg_we && idle_ok;

  assign wr_entry.steps = cfg_steps;
  assign wr_entry.regno = cfg_reg;
  assign wr_entry.val   = cfg_val;

  cts_table #(
    .NCHK (NCHK)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (cfg_idx),
    .wdata (wr_entry),
    .raddr (idx_reg),
    .rdata (rd_entry)
  );

  // On the first RUN cycle of an entry the step count comes straight from the
  // table, so a single read port addressed by idx serves both RUN and CHECK.
  assign eff_steps    = first_reg ? rd_entry.steps : step_cnt_reg;
  assign mismatch     = (dbg_rdata != rd_entry.val);
  assign last         = ({1'b0, idx_reg} == (nchk_reg - (IW+1)'(1)));
  assign nchk_clamped = (num_chk > (IW+1)'(NCHK)) ? (IW+1)'(NCHK) : num_chk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      nchk_reg      <= '0;
      rst_cnt_reg   <= '0;
      step_cnt_reg  <= '0;
      first_reg     <= 1'b0;
      err_cnt_reg   <= '0;
      fail_idx_reg  <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      nchk_reg      <= nchk_next;
      rst_cnt_reg   <= rst_cnt_next;
      step_cnt_reg  <= step_cnt_next;
      first_reg     <= first_next;
      err_cnt_reg   <= err_cnt_next;
      fail_idx_reg  <= fail_idx_next;
      cycle_cnt_reg <= cycle_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    nchk_next      = nchk_reg;
    rst_cnt_next   = rst_cnt_reg;
    step_cnt_next  = step_cnt_reg;
    first_next     = first_reg;
    err_cnt_next   = err_cnt_reg;
    fail_idx_next  = fail_idx_reg;
    cycle_cnt_next = cycle_cnt_reg;
    cpu_step       = 1'b0;
    dbg_raddr      = '0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_cnt_next   = '0;
          cycle_cnt_next = '0;
          fail_idx_next  = '0;
          idx_next       = '0;
          rst_cnt_next   = '0;
          nchk_next      = nchk_clamped;
          state_next     = ST_RESET;
        end
      end

      ST_RESET: begin
        if (rst_cnt_reg == RCW'(RST_CYC - 1)) begin
          if (nchk_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
            first_next = 1'b1;
          end
        end else begin
          rst_cnt_next = rst_cnt_reg + RCW'(1);
        end
      end

      ST_RUN: begin
        first_next = 1'b0;
        if (eff_steps != '0) begin
          cpu_step       = 1'b1;
          step_cnt_next  = eff_steps - CW'(1);
          cycle_cnt_next = sat_inc(cycle_cnt_reg);
        end else begin
          state_next = ST_CHECK;
        end
      end

      ST_CHECK: begin
        dbg_raddr = rd_entry.regno;
        if (mismatch) begin
          err_cnt_next = err_cnt_reg + (IW+1)'(1);
          if (err_cnt_reg == '0) begin
            fail_idx_next = idx_reg;
          end
        end
`ifdef CPU_TEST_SEQ_STOP_ON_FAIL_EN
        if (mismatch || last) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + IW'(1);
          first_next = 1'b1;
          state_next = ST_RUN;
        end
`else
        if (last) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + IW'(1);
          first_next = 1'b1;
          state_next = ST_RUN;
        end
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign cpu_rst   = (state_reg == ST_IDLE) || (state_reg == ST_RESET);
  assign busy      = (state_reg == ST_RESET) || (state_reg == ST_RUN) ||
                     (state_reg == ST_CHECK);
  assign done      = (state_reg == ST_DONE);
  assign pass      = done && (err_cnt_reg == '0);
  assign err_cnt   = err_cnt_reg;
  assign fail_idx  = fail_idx_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_cpu_test_seq.sv
// Scoreboard bench for cpu_test_seq: a tiny model core runs a 3-instruction
// program; each run's expected outcome is queued and checked when done rises.
module tb_cpu_test_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_chk;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_steps;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_val;
  logic        cpu_rst, cpu_step;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy, done, pass;
  logic [3:0]  err_cnt;
  logic [2:0]  fail_idx;
  logic [15:0] cycle_cnt;

  always #5 clk = ~clk;

  cpu_test_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_chk   (num_chk),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_steps (cfg_steps),
    .cfg_reg   (cfg_reg),
    .cfg_val   (cfg_val),
    .cpu_rst   (cpu_rst),
    .cpu_step  (cpu_step),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_idx  (fail_idx),
    .cycle_cnt (cycle_cnt)
  );

  // Model core: addi x6,x0,100 / addi x7,x0,20 / add x28,x6,x7, then nops.
  logic [31:0] rf [32];
  int pc;
  always @(posedge clk) begin
    if (cpu_rst) begin
      pc <= 0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (cpu_step) begin
      case (pc)
        0: rf[6]  <= 32'd100;
        1: rf[7]  <= 32'd20;
        2: rf[28] <= rf[6] + rf[7];
        default: ;
      endcase
      pc <= pc + 1;
    end
  end
  assign dbg_rdata = rf[dbg_raddr];

  typedef struct {
    int    lat;
    int    pas;
    int    err;
    int    fidx;
    int    cyc;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc_no++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares the head of the scoreboard on each rising edge of done.
  initial begin
    exp_t x;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          x = sb.pop_front();
          $display("txn %s: lat=%0d pass=%0d err=%0d fidx=%0d cyc=%0d", x.nm,
                   cyc_no - start_cyc, pass, err_cnt, fail_idx, cycle_cnt);
          check({x.nm, "_lat"},  64'(cyc_no - start_cyc), 64'(x.lat));
          check({x.nm, "_pass"}, 64'(pass),      64'(x.pas));
          check({x.nm, "_err"},  64'(err_cnt),   64'(x.err));
          check({x.nm, "_fidx"}, 64'(fail_idx),  64'(x.fidx));
          check({x.nm, "_cyc"},  64'(cycle_cnt), 64'(x.cyc));
          check({x.nm, "_frozen"}, 64'({cpu_rst, cpu_step, busy}), 64'd0);
        end
      end
      done_q = (done === 1'b1);
    end
  end

  task automatic wr(input int idx, input int steps, input int r, input int v);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_steps = 16'(steps);
    cfg_reg = 5'(r); cfg_val = 32'(v);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Pulses start (optionally with a same-cycle table write) and queues the
  // expected outcome when push is set.
  task automatic launch(input int n, input bit push, input int lat, input int p,
                        input int e, input int f, input int c, input string nm,
                        input bit we = 1'b0, input int widx = 0, input int wst = 0,
                        input int wreg = 0, input int wval = 0);
    exp_t x;
    @(posedge clk); #1;
    num_chk = 4'(n);
    start   = 1'b1;
    if (we) begin
      cfg_we = 1'b1; cfg_idx = 3'(widx); cfg_steps = 16'(wst);
      cfg_reg = 5'(wreg); cfg_val = 32'(wval);
    end
    start_cyc = cyc_no + 1;
    if (push) begin
      x.lat = lat; x.pas = p; x.err = e; x.fidx = f; x.cyc = c; x.nm = nm;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic load_prog;
    wr(0, 1, 6, 100);
    wr(1, 1, 7, 20);
    wr(2, 1, 28, 120);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; num_chk = '0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_steps = '0; cfg_reg = '0; cfg_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst",  64'(cpu_rst),   64'd1);
    check("rst_cpu_step", 64'(cpu_step),  64'd0);
    check("rst_busy",     64'(busy),      64'd0);
    check("rst_done",     64'(done),      64'd0);
    check("rst_pass",     64'(pass),      64'd0);
    check("rst_err",      64'(err_cnt),   64'd0);
    check("rst_fidx",     64'(fail_idx),  64'd0);
    check("rst_cyc",      64'(cycle_cnt), 64'd0);
    check("rst_raddr",    64'(dbg_raddr), 64'd0);
    rst = 1'b0;

    // latency = RST_CYC + sum(steps+2) edges from the start-sampling edge
    load_prog();
    launch(3, 1'b1, 11, 1, 0, 0, 3, "basic");
    drain(200);

    wr(2, 1, 28, 121);
    launch(3, 1'b1, 11, 0, 1, 2, 3, "bad_last");
    drain(200);

    wr(0, 0, 0, 0);
    wr(1, 3, 28, 120);
    launch(2, 1'b1, 9, 1, 0, 0, 3, "zero_step");
    drain(200);

    wr(0, 1, 6, 99);
    wr(1, 1, 7, 21);
    wr(2, 1, 28, 120);
`ifdef CPU_TEST_SEQ_STOP_ON_FAIL_EN
    launch(3, 1'b1, 5, 0, 1, 0, 1, "two_bad");
`else
    launch(3, 1'b1, 11, 0, 2, 0, 3, "two_bad");
`endif
    drain(200);

    // Reset during entry 1's RUN, identified by the second step pulse.
    load_prog();
    launch(3, 1'b0, 0, 0, 0, 0, 0, "abort");
    seen = 0;
    for (int i = 0; i < 50 && seen < 2; i++) begin
      @(negedge clk);
      if (cpu_step === 1'b1) seen++;
    end
    check("abort_steps_seen", 64'(seen), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",    64'(busy),      64'd0);
    check("abort_cpu_rst", 64'(cpu_rst),   64'd1);
    check("abort_done",    64'(done),      64'd0);
    check("abort_cyc",     64'(cycle_cnt), 64'd0);
    rst = 1'b0;
    launch(3, 1'b1, 11, 1, 0, 0, 3, "after_rst");
    drain(200);

    launch(0, 1'b1, 2, 1, 0, 0, 0, "empty");
    drain(100);

    // num_chk above NCHK clamps to 8; a start pulse mid-run must be ignored.
    for (int i = 3; i < 8; i++) wr(i, 0, 0, 0);
    launch(15, 1'b1, 21, 1, 0, 0, 3, "clamp_busy_start");
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(200);

    // Same-cycle write lands before the run; a write while busy is dropped.
    launch(3, 1'b1, 11, 0, 1, 2, 3, "we_with_start", 1'b1, 2, 1, 28, 121);
    repeat (3) @(posedge clk);
    wr(0, 1, 6, 555);
    drain(200);
    launch(3, 1'b1, 11, 0, 1, 2, 3, "we_busy_dropped");
    drain(200);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
